// File: rtl/operand_pairer_pkg.sv
// Shared defaults and types for the operand pairer (adder feeder stage).
// Optional statistics outputs are enabled with OPERAND_PAIRER_STATS_EN.
package operand_pairer_pkg;

    localparam int DATA_W_DEFAULT     = 32;
    localparam int FIFO_DEPTH_DEFAULT = 4;
    localparam int LEVEL_W_DEFAULT    = $clog2(FIFO_DEPTH_DEFAULT) + 1;

    typedef struct packed {
        logic [DATA_W_DEFAULT-1:0] a;
        logic [DATA_W_DEFAULT-1:0] b;
    } operand_pair_t;

    // Occupancy needs one bit more than the address so a full FIFO reads as DEPTH.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a synchronous clear; head word is shown combinationally on rdata.
// Full/empty are told apart by an extra wrap bit on each pointer.
module sync_fifo
    import operand_pairer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = FIFO_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !clr) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/operand_pairer.sv
// Pairs two buffered operand streams in arrival order into one registered din0/din1 beat.
// Define OPERAND_PAIRER_STATS_EN to add pair/starvation counters.
module operand_pairer
    import operand_pairer_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             a_tdata,
    input  logic                          a_tvalid,
    output logic                          a_tready,
    input  logic [DATA_W-1:0]             b_tdata,
    input  logic                          b_tvalid,
    output logic                          b_tready,
    input  logic                          hold,
    input  logic                          flush,
    output logic [DATA_W-1:0]             din0,
    output logic [DATA_W-1:0]             din1,
    output logic                          din_valid,
    output logic [$clog2(FIFO_DEPTH):0]   a_level,
    output logic [$clog2(FIFO_DEPTH):0]   b_level
`ifdef OPERAND_PAIRER_STATS_EN
    ,
    output logic [31:0]                   pair_count,
    output logic [31:0]                   a_starve_cycles,
    output logic [31:0]                   b_starve_cycles
`endif
);

    logic              a_full, a_empty, b_full, b_empty;
    logic              a_push, b_push, pop;
    logic [DATA_W-1:0] a_head, b_head;

    // Handshake: a beat transfers on a clk edge where tvalid && tready. tready
    // depends only on registered fullness, rst and flush, never on a same-cycle
    // pop, so a full FIFO refuses input even while it is draining.
    assign a_tready = !a_full && !rst && !flush;
    assign b_tready = !b_full && !rst && !flush;
    assign a_push   = a_tvalid && a_tready;
    assign b_push   = b_tvalid && b_tready;
    assign pop      = !a_empty && !b_empty && !hold && !flush;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (a_push),
        .wdata (a_tdata),
        .pop   (pop),
        .rdata (a_head),
        .full  (a_full),
        .empty (a_empty),
        .level (a_level)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (b_push),
        .wdata (b_tdata),
        .pop   (pop),
        .rdata (b_head),
        .full  (b_full),
        .empty (b_empty),
        .level (b_level)
    );

    // Operands persist between beats; only din_valid marks a new pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            din0      <= '0;
            din1      <= '0;
            din_valid <= 1'b0;
        end else if (pop) begin
            din0      <= a_head;
            din1      <= b_head;
            din_valid <= 1'b1;
        end else begin
            din_valid <= 1'b0;
        end
    end

`ifdef OPERAND_PAIRER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pair_count      <= '0;
            a_starve_cycles <= '0;
            b_starve_cycles <= '0;
        end else begin
            if (din_valid)                    pair_count      <= pair_count + 32'd1;
            if (!b_empty && a_empty && !hold) a_starve_cycles <= a_starve_cycles + 32'd1;
            if (!a_empty && b_empty && !hold) b_starve_cycles <= b_starve_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_operand_pairer.sv
// Directed bench for operand_pairer: reset, pairing latency, skew, hold/full, flush,
// mid-stream reset and a full-rate stream checked against an expected queue.
module tb_operand_pairer;
    import operand_pairer_pkg::*;

    localparam int DW = DATA_W_DEFAULT;
    localparam int LW = level_w(FIFO_DEPTH_DEFAULT);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] a_tdata = '0, b_tdata = '0;
    logic          a_tvalid = 1'b0, b_tvalid = 1'b0;
    logic          a_tready, b_tready;
    logic          hold = 1'b0, flush = 1'b0;
    logic [DW-1:0] din0, din1;
    logic          din_valid;
    logic [LW-1:0] a_level, b_level;
`ifdef OPERAND_PAIRER_STATS_EN
    logic [31:0]   pair_count, a_starve_cycles, b_starve_cycles;
`endif

    int checks   = 0;
    int failures = 0;
    logic [2*DW-1:0] exp_q[$];

    operand_pairer dut (
        .clk       (clk),
        .rst       (rst),
        .a_tdata   (a_tdata),
        .a_tvalid  (a_tvalid),
        .a_tready  (a_tready),
        .b_tdata   (b_tdata),
        .b_tvalid  (b_tvalid),
        .b_tready  (b_tready),
        .hold      (hold),
        .flush     (flush),
        .din0      (din0),
        .din1      (din1),
        .din_valid (din_valid),
        .a_level   (a_level),
        .b_level   (b_level)
`ifdef OPERAND_PAIRER_STATS_EN
        ,
        .pair_count      (pair_count),
        .a_starve_cycles (a_starve_cycles),
        .b_starve_cycles (b_starve_cycles)
`endif
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int npairs, nb, sent, n_got, gaps, first_cyc, stalls;
        logic a_acc, a_now, b_now, acc;
        operand_pair_t p;

        // Reset state
        tick(); tick();
        chk("rst_din_valid", din_valid, 0);
        chk("rst_din0", din0, 0);
        chk("rst_din1", din1, 0);
        chk("rst_a_level", a_level, 0);
        chk("rst_b_level", b_level, 0);
        chk("rst_a_tready", a_tready, 0);
        chk("rst_b_tready", b_tready, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_a_tready", a_tready, 1);
        chk("post_rst_b_tready", b_tready, 1);

        // Basic pair: same-cycle A=5, B=7
        a_tdata = 5; a_tvalid = 1; b_tdata = 7; b_tvalid = 1;
        tick();
        a_tvalid = 0; b_tvalid = 0;
        chk("basic_lat1_valid", din_valid, 0);
        chk("basic_a_level", a_level, 1);
        tick();
        chk("basic_valid", din_valid, 1);
        chk("basic_din0", din0, 5);
        chk("basic_din1", din1, 7);
        tick();
        chk("basic_one_beat", din_valid, 0);
        chk("basic_din0_hold", din0, 5);

        // Skewed arrival: A 1,2,3 then B 10,20,30 after 10 idle cycles
        for (int i = 1; i <= 3; i++) begin
            a_tdata = DW'(i); a_tvalid = 1;
            tick();
        end
        a_tvalid = 0;
        chk("skew_a_level_peak", a_level, 3);
        repeat (10) tick();
        chk("skew_idle_valid", din_valid, 0);
        chk("skew_idle_a_level", a_level, 3);
        b_tdata = 10; b_tvalid = 1;
        tick();
        chk("skew_b_first_valid", din_valid, 0);
        for (int i = 1; i <= 3; i++) begin
            b_tdata = DW'(10 * (i + 1));
            b_tvalid = (i < 3);
            tick();
            chk("skew_valid", din_valid, 1);
            chk("skew_din0", din0, i);
            chk("skew_din1", din1, 10 * i);
        end
        tick();
        chk("skew_done_valid", din_valid, 0);
        chk("skew_done_a_level", a_level, 0);

        // Backpressure: hold high, five A beats into a depth-4 FIFO
        hold = 1;
        for (int i = 0; i < 4; i++) begin
            a_tdata = DW'(100 + i); a_tvalid = 1;
            #1;
            chk("bp_tready_open", a_tready, 1);
            tick();
        end
        a_tdata = 104;
        chk("bp_tready_full", a_tready, 0);
        chk("bp_a_level_full", a_level, 4);
        tick(); tick();
        chk("bp_still_full", a_level, 4);
        chk("bp_no_pop", din_valid, 0);
        hold = 0; nb = 0; npairs = 0; a_acc = 0;
        for (int c = 0; c < 12; c++) begin
            b_tvalid = (nb < 4); b_tdata = DW'(200 + nb);
            #1;
            a_now = a_tvalid && a_tready;
            b_now = b_tvalid && b_tready;
            tick();
            if (b_now) nb++;
            if (a_now) begin
                a_tvalid = 0;
                a_acc = 1;
                chk("bp_5th_after_pop", (npairs >= 1), 1);
            end
            if (din_valid) begin
                chk("bp_din0", din0, 100 + npairs);
                chk("bp_din1", din1, 200 + npairs);
                npairs++;
            end
        end
        b_tvalid = 0;
        chk("bp_pair_count", npairs, 4);
        chk("bp_5th_accepted", a_acc, 1);
        chk("bp_a_level_end", a_level, 1);
        chk("bp_b_level_end", b_level, 0);

        // Flush: discard leftovers, refill A with two, flush with a junk beat offered
        flush = 1; tick(); flush = 0;
        chk("flush0_a_level", a_level, 0);
        a_tvalid = 1;
        a_tdata = 32'hAAAA_0001; tick();
        a_tdata = 32'hAAAA_0002; tick();
        chk("flush_pre_a_level", a_level, 2);
        flush = 1; a_tdata = 32'hDEAD_BEEF; b_tdata = 32'h1234; b_tvalid = 1;
        #1;
        chk("flush_a_tready", a_tready, 0);
        chk("flush_b_tready", b_tready, 0);
        tick();
        flush = 0; a_tvalid = 0; b_tvalid = 0;
        chk("flush_a_level", a_level, 0);
        chk("flush_b_level", b_level, 0);
        chk("flush_valid", din_valid, 0);
        a_tdata = 32'hFFFF_FFFF; a_tvalid = 1; b_tdata = 9; b_tvalid = 1;
        tick();
        a_tvalid = 0; b_tvalid = 0;
        tick();
        chk("flush_pair_valid", din_valid, 1);
        chk("flush_pair_din0", din0, 32'hFFFF_FFFF);
        chk("flush_pair_din1", din1, 9);
        tick();
        chk("flush_no_stale", din_valid, 0);
        chk("flush_end_a_level", a_level, 0);

        // Reset mid-stream with 3 pairs pending behind hold
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            a_tdata = DW'(50 + i); b_tdata = DW'(60 + i);
            a_tvalid = 1; b_tvalid = 1;
            tick();
        end
        a_tvalid = 0; b_tvalid = 0;
        chk("mrst_pending", a_level, 3);
        rst = 1; hold = 0;
        tick();
        chk("mrst_valid", din_valid, 0);
        chk("mrst_din0", din0, 0);
        chk("mrst_din1", din1, 0);
        chk("mrst_a_level", a_level, 0);
        chk("mrst_b_level", b_level, 0);
        chk("mrst_a_tready", a_tready, 0);
        chk("mrst_b_tready", b_tready, 0);
        rst = 0;
        #1;
        chk("mrst_after_a_tready", a_tready, 1);
        chk("mrst_after_b_tready", b_tready, 1);
        tick(); tick();
        chk("mrst_no_partial", din_valid, 0);

        // Full-rate stream of 1000 pairs
        sent = 0; n_got = 0; gaps = 0; first_cyc = -1; stalls = 0;
        for (int c = 0; c < 1100 && n_got < 1000; c++) begin
            a_tvalid = (sent < 1000); b_tvalid = (sent < 1000);
            a_tdata = $urandom; b_tdata = $urandom;
            #1;
            acc = a_tvalid && a_tready && b_tready;
            if (a_tvalid && !(a_tready && b_tready)) stalls++;
            if (acc) begin
                p.a = a_tdata; p.b = b_tdata;
                exp_q.push_back(p);
            end
            tick();
            if (acc) sent++;
            if (c == 500) begin
                chk("stream_a_level", a_level, 1);
                chk("stream_b_level", b_level, 1);
            end
            if (din_valid) begin
                if (first_cyc < 0) first_cyc = c;
                if (exp_q.size() == 0) chk("stream_extra", {din0, din1}, 64'hx);
                else chk("stream_pair", {din0, din1}, exp_q.pop_front());
                n_got++;
            end else if (first_cyc >= 0 && n_got < 1000) begin
                gaps++;
            end
        end
        a_tvalid = 0; b_tvalid = 0;
        chk("stream_first_latency", first_cyc, 1);
        chk("stream_count", n_got, 1000);
        chk("stream_gaps", gaps, 0);
        chk("stream_stalls", stalls, 0);
        chk("stream_leftover", exp_q.size(), 0);
`ifdef OPERAND_PAIRER_STATS_EN
        tick();
        chk("stats_pair_count", pair_count, 1000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
